// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// State encoding, BCD digit constants and a digit validity helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load and borrow chaining.
// Wraps from zero to WRAP when a decrement borrows through it.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_NINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] r_q;

  // Digit register: load wins over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= BCD_ZERO;
    end else if (ld) begin
      r_q <= d;
    end else if (dec) begin
      r_q <= (r_q == BCD_ZERO) ? WRAP : r_q - 4'd1;
    end
  end

  assign q          = r_q;
  assign borrow_out = dec && (r_q == BCD_ZERO);

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with run/pause/expire control.
// Decrements on the 1 Hz strobe, stops at 00:00 with a done pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_MAX = 99,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       ld,
  input  logic [7:0] d_min,
  input  logic [7:0] d_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] q_min,
  output logic [7:0] q_sec,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam logic [3:0] SEC_T = 4'(SEC_MAX / 10);
  localparam logic [3:0] SEC_O = 4'(SEC_MAX % 10);
  localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_O = 4'(MIN_MAX % 10);
  localparam logic [7:0] SEC_MAX_BCD = {SEC_T, SEC_O};
  localparam logic [7:0] MIN_MAX_BCD = {MIN_T, MIN_O};

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_done;

  logic [7:0] w_sec_val;
  logic [7:0] w_min_val;
  logic       w_sec_ok;
  logic       w_min_ok;
  logic [7:0] w_sec_ld;
  logic [7:0] w_min_ld;

  logic [3:0] w_s0;
  logic [3:0] w_s1;
  logic [3:0] w_m0;
  logic [3:0] w_m1;
  logic       w_b0;
  logic       w_b1;
  logic       w_b2;
  logic       w_b3;

  logic       w_q_zero;
  logic       w_q_one;
  logic       w_tick;
  logic       w_term;

  // Per-field clamping of the preset into the legal range.
  always_comb begin
    w_sec_val = {4'd0, d_sec[7:4]} * 8'd10 + {4'd0, d_sec[3:0]};
    w_min_val = {4'd0, d_min[7:4]} * 8'd10 + {4'd0, d_min[3:0]};
    w_sec_ok  = bcd_valid(d_sec[7:4]) && bcd_valid(d_sec[3:0])
             && (w_sec_val <= 8'(SEC_MAX));
    w_min_ok  = bcd_valid(d_min[7:4]) && bcd_valid(d_min[3:0])
             && (w_min_val <= 8'(MIN_MAX));
    w_sec_ld  = w_sec_ok ? d_sec : SEC_MAX_BCD;
    w_min_ld  = w_min_ok ? d_min : MIN_MAX_BCD;
  end

  assign w_q_zero = ({w_m1, w_m0, w_s1, w_s0} == 16'h0000);
  assign w_q_one  = ({w_m1, w_m0, w_s1, w_s0} == 16'h0001);
  assign w_tick   = ce && (r_state == RUN) && !ld && !stop && !w_q_zero;
  assign w_term   = w_tick && w_q_one;

  bcd_down_digit #(.WRAP(BCD_NINE)) u_sec_ones (
    .clk        (clk),
    .rst        (rst),
    .dec        (w_tick),
    .ld         (ld),
    .d          (w_sec_ld[3:0]),
    .q          (w_s0),
    .borrow_out (w_b0)
  );

  bcd_down_digit #(.WRAP(SEC_T)) u_sec_tens (
    .clk        (clk),
    .rst        (rst),
    .dec        (w_b0),
    .ld         (ld),
    .d          (w_sec_ld[7:4]),
    .q          (w_s1),
    .borrow_out (w_b1)
  );

  bcd_down_digit #(.WRAP(BCD_NINE)) u_min_ones (
    .clk        (clk),
    .rst        (rst),
    .dec        (w_b1),
    .ld         (ld),
    .d          (w_min_ld[3:0]),
    .q          (w_m0),
    .borrow_out (w_b2)
  );

  bcd_down_digit #(.WRAP(BCD_NINE)) u_min_tens (
    .clk        (clk),
    .rst        (rst),
    .dec        (w_b2),
    .ld         (ld),
    .d          (w_min_ld[7:4]),
    .q          (w_m1),
    .borrow_out (w_b3)
  );

  // Next-state logic with ld > stop > start > ce priority.
  always_comb begin
    w_state_nxt = r_state;
    if (ld) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, PAUSE: begin
          if (!stop && start && !w_q_zero) w_state_nxt = RUN;
        end
        RUN: begin
          if (stop)                 w_state_nxt = PAUSE;
          else if (w_term || w_b3)  w_state_nxt = EXPIRED;
        end
        EXPIRED: begin
          if (stop) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State and done-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_term;
    end
  end

  assign q_min   = {w_m1, w_m0};
  assign q_sec   = {w_s1, w_s0};
  assign running = (r_state == RUN);
  assign expired = (r_state == EXPIRED);
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Expected values are hand-computed BCD mm:ss constants.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       ld;
  logic [7:0] d_min;
  logic [7:0] d_sec;
  logic       start;
  logic       stop;
  logic [7:0] q_min;
  logic [7:0] q_sec;
  logic       running;
  logic       expired;
  logic       done;

  int n_chk;
  int n_err;

  countdown_timer #(.MIN_MAX(99), .SEC_MAX(59)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .ld      (ld),
    .d_min   (d_min),
    .d_sec   (d_sec),
    .start   (start),
    .stop    (stop),
    .q_min   (q_min),
    .q_sec   (q_sec),
    .running (running),
    .expired (expired),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] s);
    d_min = m;
    d_sec = s;
    ld    = 1'b1;
    cyc();
    ld    = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    ce = 1'b1;
    repeat (n) cyc();
    ce = 1'b0;
  endtask

  task automatic chk_q(input string tag, input logic [15:0] exp);
    chk(tag, {q_min, q_sec}, exp);
  endtask

  task automatic chk_f(input string tag, input logic [2:0] exp);
    chk(tag, {13'd0, running, expired, done}, {13'd0, exp});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b0;
    ce    = 1'b0;
    ld    = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    d_min = 8'h00;
    d_sec = 8'h00;
    #2;
    chk_q("rst_q", 16'h0000);
    chk_f("rst_flags", 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    load(8'h01, 8'h00);
    chk_q("ld_0100", 16'h0100);
    go();
    chk_f("run_0100", 3'b100);
    ticks(1);
    chk_q("dec_0059", 16'h0059);
    chk_f("run_0059", 3'b100);

    load(8'h10, 8'h00);
    go();
    ticks(1);
    chk_q("dec_0959", 16'h0959);

    load(8'h00, 8'h03);
    go();
    ce = 1'b1;
    cyc();
    chk_q("t3_0002", 16'h0002);
    chk_f("t3_f2", 3'b100);
    cyc();
    chk_q("t3_0001", 16'h0001);
    chk_f("t3_f1", 3'b100);
    cyc();
    chk_q("t3_0000", 16'h0000);
    chk_f("t3_done", 3'b011);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_q("exp_hold_q", 16'h0000);
      chk_f("exp_hold_f", 3'b010);
    end
    ce = 1'b0;

    load(8'h02, 8'h30);
    go();
    ticks(2);
    chk_q("p_0228", 16'h0228);
    halt();
    chk_f("p_pause", 3'b000);
    ticks(4);
    chk_q("p_hold", 16'h0228);
    chk_f("p_hold_f", 3'b000);
    go();
    chk_f("p_resume", 3'b100);
    ticks(1);
    chk_q("p_0227", 16'h0227);

    load(8'h00, 8'h05);
    go();
    ce    = 1'b1;
    d_min = 8'h00;
    d_sec = 8'h07;
    ld    = 1'b1;
    cyc();
    ld    = 1'b0;
    ce    = 1'b0;
    chk_q("ld_ce_q", 16'h0007);
    chk_f("ld_ce_f", 3'b000);

    load(8'hA5, 8'h7C);
    chk_q("clamp_both", 16'h9959);
    chk_f("clamp_idle", 3'b000);
    load(8'h42, 8'h65);
    chk_q("clamp_sec", 16'h4259);
    load(8'h00, 8'h00);
    go();
    chk_f("start_zero", 3'b000);

    load(8'h00, 8'h01);
    go();
    ticks(1);
    chk_f("e_enter", 3'b011);
    go();
    chk_f("e_start", 3'b010);
    chk_q("e_start_q", 16'h0000);
    halt();
    chk_f("e_ack", 3'b000);
    chk_q("e_ack_q", 16'h0000);
    load(8'h00, 8'h10);
    chk_q("e_ld", 16'h0010);

    load(8'h05, 8'h17);
    go();
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk_f("ss_pause", 3'b000);
    chk_q("ss_q", 16'h0517);
    go();
    chk_f("ss_rerun", 3'b100);

    load(8'h00, 8'h01);
    go();
    ce = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_q("arst_q", 16'h0000);
    chk_f("arst_f", 3'b000);
    cyc();
    chk_f("arst_nodone", 3'b000);
    ce  = 1'b0;
    rst = 1'b1;
    cyc();
    chk_f("post_rst", 3'b000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD minutes:seconds down-counter for the lab clock/alarm design; the countdown complement of the clock-enabled up-counter.
- Loads a preset, decrements once per 1 Hz enable tick while running, stops at 00:00 and raises a done pulse and a sticky expired flag.
- Feeds the display mux and the alarm/buzzer logic.

Parameters:
- MIN_MAX, 99, largest loadable minutes value (BCD-interpreted, 00..99)
- SEC_MAX, 59, largest seconds value; fixed 59 in normal use, exposed for short-period simulation

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ce  in  1  one-cycle tick (1 Hz strobe); counts only in RUN
- ld  in  1  synchronous load of d_min/d_sec
- d_min  in  8  BCD preset minutes {tens, ones}
- d_sec  in  8  BCD preset seconds {tens, ones}
- start  in  1  begin/resume countdown
- stop  in  1  pause; acknowledges expiry
- q_min  out  8  BCD current minutes
- q_sec  out  8  BCD current seconds
- running  out  1  high in RUN
- expired  out  1  sticky, high in EXPIRED
- done  out  1  one-cycle pulse on reaching 00:00

Behaviour:
- Reset (rst=0, async): q_min=8'h00, q_sec=8'h00, state IDLE, running=0, expired=0, done=0. Release synchronous to clk.
- All outputs registered; every input effect is visible the cycle after the sampling edge.
- States: IDLE, RUN, PAUSE, EXPIRED. running = (state==RUN); expired = (state==EXPIRED).
- Priority each edge: rst > ld > stop > start > ce.
- ld, any state: q loaded from d; state->IDLE; expired cleared; done=0. Not gated by ce.
- Clamping on load: any seconds digit >9 or seconds tens >5 loads q_sec=SEC_MAX. Any minutes digit >9 or value >MIN_MAX loads q_min=MIN_MAX. Clamping is per field.
- start in IDLE or PAUSE with q != 00:00 -> RUN. start with q == 00:00 -> stays IDLE. start in RUN or EXPIRED is ignored.
- stop in RUN -> PAUSE. stop in EXPIRED -> IDLE (acknowledge; expired clears, q stays 00:00). stop in IDLE or PAUSE is ignored.
- start and stop in the same cycle: stop wins.
- ce in RUN decrements by one second:
  - sec ones 0->9 with borrow;
  - sec tens 0->5 (SEC_MAX tens) with borrow;
  - min ones 0->9 with borrow;
  - min tens decrements.
  - Example: 10:00 -> 09:59.
- Terminal: ce in RUN with q == 00:01 -> q=00:00, state EXPIRED, done=1 for exactly that one cycle.
- No wrap below 00:00. EXPIRED holds 00:00 and ignores ce.
- ce outside RUN has no effect. ce coincident with ld or stop is ignored (the higher-priority event wins).
- ce held high continuously in RUN decrements every cycle; legal, used for fast simulation.
- Reset mid-RUN: immediate return to the reset state; done never asserts on reset.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, EXPIRED=2'b11);
  - BCD constants (BCD_NINE=4'h9, BCD_ZERO=4'h0);
  - helper function bcd_valid(digit).
- One sub-module: bcd_down_digit.
  - Parameterized wrap value.
  - Inputs: dec (borrow in), ld, d.
  - Outputs: q[3:0], borrow_out, asserted when dec && q==0.
- Four instances are chained for sec ones, sec tens (wrap 5), min ones, min tens (wrap 9, never wraps because of the terminal stop).
- FSM and clamping logic live in the top module.

Test Plan:
- Reset then ld d_min=8'h01 d_sec=8'h00, start, 1 ce -> q=00:59, running=1.
- Load 00:03, start, 3 ce pulses -> q steps 00:02, 00:01, 00:00; done=1 one cycle on the 00:00 cycle; expired=1 and stays 1; 5 more ce leave q=00:00, done=0.
- Load 02:30, start, 2 ce, stop, 4 ce, start, 1 ce -> q=02:27; running low only during the pause.
- Load d_min=8'hA5 d_sec=8'h7C -> q_min=8'h99, q_sec=8'h59, state IDLE. Load 00:00 then start -> running stays 0.
- In EXPIRED: start -> no change; stop -> expired=0, state IDLE; ld 00:10 -> q=00:10.
- Mid-RUN at 05:17: start+stop same cycle -> PAUSE. Then rst low asynchronously between edges -> q=00:00, all flags 0 immediately, done never pulses.
